// File: rtl/input_pkg.sv
// Shared types and constants for the button event arbiter: FSM encoding,
// event polarity and a constant-friendly ceil(log2) for index widths.
package input_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TIMING = 2'd1,
      COMMIT = 2'd2
   } arb_state_e;

   localparam logic EVT_PRESS   = 1'b1;
   localparam logic EVT_RELEASE = 1'b0;

   // Never returns less than 1 so a two-button build still gets a real index bit.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            width = i + 1;
         end
      end
      return width;
   endfunction

endpackage

// File: rtl/evt_fifo.sv
// Small first-word-fall-through FIFO. The head word lives in its own register
// so the consumer sees a flop output that holds steady until it is popped.
module evt_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             full_o,
   input  logic             pop_i,
   output logic             empty_o,
   output logic [WIDTH-1:0] dout_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW-1:0]    rd_ptr_d;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] head_d;
   logic             push_ok;
   logic             pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   // A write landing exactly where the next head will sit bypasses the array.
   always_comb begin
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      head_d   = (push_ok && (wr_ptr_q == rd_ptr_d)) ? din_i : mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_ok || pop_ok) begin
            head_q <= head_d;
         end
      end
   end

   assign dout_o = head_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounces NUM_BTN buttons with a single timer handed out round-robin and
// queues committed press/release edges as one-shot events.
module button_event_arbiter
   import input_pkg::*;
#(
   parameter int NUM_BTN    = 4,
   parameter int DELAY      = 300000,
   parameter int CNT_W      = 22,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_BTN-1:0]        btn_raw,
   output logic [NUM_BTN-1:0]        btn_clean,
   output logic                      evt_valid,
   input  logic                      evt_ready,
   output logic [clog2(NUM_BTN)-1:0] evt_id,
   output logic                      evt_press,
   output logic                      evt_ovf,
   input  logic                      ovf_clr,
   output logic                      busy
);

   localparam int                ID_W      = clog2(NUM_BTN);
   localparam int                EVT_W     = ID_W + 1;
   localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(DELAY - 1);
   localparam logic [ID_W-1:0]   LAST_IDX  = ID_W'(NUM_BTN - 1);

   logic [NUM_BTN-1:0] meta_q;
   logic [NUM_BTN-1:0] sync_q;
   logic [NUM_BTN-1:0] clean_q;
   logic [NUM_BTN-1:0] cand;
   arb_state_e         state_q;
   logic [ID_W-1:0]    idx_q;
   logic [ID_W-1:0]    idx_inc;
   logic [ID_W-1:0]    rr_ptr_q;
   logic [ID_W-1:0]    pick_idx_d;
   logic [ID_W-1:0]    scan_idx;
   logic               pick_found_d;
   logic [CNT_W-1:0]   timer_q;
   logic               busy_q;
   logic               ovf_q;
   logic               push;
   logic               drop;
   logic               evt_kind;
   logic               fifo_full;
   logic               fifo_empty;
   logic [EVT_W-1:0]   push_data;
   logic [EVT_W-1:0]   head_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= btn_raw;
         sync_q <= meta_q;
      end
   end

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_cand
      assign cand[gi] = sync_q[gi] ^ clean_q[gi];
   end

   assign idx_inc = (idx_q == LAST_IDX) ? '0 : idx_q + ID_W'(1);

   // Walk the ring backwards so the candidate closest to rr_ptr is written last.
   always_comb begin
      pick_found_d = 1'b0;
      pick_idx_d   = '0;
      scan_idx     = '0;
      for (int k = NUM_BTN - 1; k >= 0; k--) begin
         scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_BTN);
         if (cand[scan_idx]) begin
            pick_found_d = 1'b1;
            pick_idx_d   = scan_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         timer_q  <= '0;
         rr_ptr_q <= '0;
         busy_q   <= 1'b0;
         clean_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pick_found_d) begin
                  idx_q   <= pick_idx_d;
                  timer_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= TIMING;
               end
            end
            TIMING: begin
               if (!cand[idx_q]) begin
                  rr_ptr_q <= idx_inc;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end else if (timer_q == LAST_TICK) begin
                  state_q <= COMMIT;
               end else begin
                  timer_q <= timer_q + CNT_W'(1);
               end
            end
            COMMIT: begin
               clean_q[idx_q] <= sync_q[idx_q];
               rr_ptr_q       <= idx_inc;
               busy_q         <= 1'b0;
               state_q        <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign evt_kind  = sync_q[idx_q] ? EVT_PRESS : EVT_RELEASE;
   assign push      = (state_q == COMMIT);
   assign push_data = {idx_q, evt_kind};
   // A full queue only loses the event when the consumer is not freeing a slot.
   assign drop      = push && fifo_full && !(evt_valid && evt_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end else if (ovf_clr) begin
         ovf_q <= 1'b0;
      end
   end

   evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (push_data),
      .full_o  (fifo_full),
      .pop_i   (evt_ready),
      .empty_o (fifo_empty),
      .dout_o  (head_data)
   );

   assign evt_valid = !fifo_empty;
   assign evt_id    = head_data[EVT_W-1:1];
   assign evt_press = head_data[0];
   assign btn_clean = clean_q;
   assign busy      = busy_q;
   assign evt_ovf   = ovf_q;

endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Shares one debounce timer, round-robin, among NUM_BTN raw player buttons.
- Maintains a debounced level per button.
- Queues press/release events in a small FIFO with a valid/ready handshake, so game logic consumes one-shot actions instead of levels.
- Sits between the board button pins and the player-input/game-state FSMs. Replaces one counter per button.

Parameters:
- NUM_BTN, 4, number of raw button inputs (2..8).
- DELAY, 300000, stable cycles required before a change is committed (>=2).
- CNT_W, 22, timer width; must satisfy 2**CNT_W > DELAY.
- FIFO_DEPTH, 4, event queue entries (power of 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_raw  in  NUM_BTN  unsynchronized button pins, 1 = pressed
- btn_clean  out  NUM_BTN  debounced level per button
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head this cycle
- evt_id  out  clog2(NUM_BTN)  button index of head event
- evt_press  out  1  1 = press, 0 = release
- evt_ovf  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears evt_ovf
- busy  out  1  timer is currently assigned to a button

Behaviour:
- Reset (async, rst=1):
  - Synchronizers, btn_clean, evt_ovf, busy all 0.
  - FIFO empty, so evt_valid=0.
  - rr_ptr=0, state=IDLE, timer=0.
  - Reset mid-TIMING aborts the candidate; no event is produced.
- Each btn_raw bit passes through a 2-flop synchronizer giving sync[i]. All logic below uses sync.
- Candidate: any i with sync[i] != btn_clean[i].
- FSM states IDLE, TIMING, COMMIT:
  - IDLE: search from rr_ptr upward, wrapping, for the first candidate. If found, latch idx, clear timer, go to TIMING, busy=1. Otherwise stay in IDLE.
  - TIMING:
    - If sync[idx]==btn_clean[idx] (bounce back): go to IDLE, rr_ptr=idx+1 mod NUM_BTN, busy=0, no event.
    - Else, if timer==DELAY-1: go to COMMIT.
    - Else timer+1.
  - COMMIT:
    - btn_clean[idx] <= sync[idx].
    - Push {idx, sync[idx]} into the FIFO.
    - rr_ptr = idx+1 mod NUM_BTN, busy=0, go to IDLE.
- Latency, uncontended: btn_clean changes DELAY+2 cycles after the first IDLE cycle that sees the candidate, i.e. DELAY+4 cycles after the sampled btn_raw edge.
- Non-selected buttons are not timed. Their pending changes wait for the timer to become free. Round-robin bounds the wait to (NUM_BTN-1)*(DELAY+2) cycles.
- FIFO push and overflow:
  - Push when not full: accepted.
  - Push when full with pop (evt_valid&evt_ready) in the same cycle: accepted.
  - Push when full without pop: dropped, evt_ovf<=1. btn_clean still updates.
- ovf_clr clears evt_ovf. If ovf_clr and a drop occur in the same cycle, set wins.
- FIFO handshake:
  - evt_id and evt_press are registered FIFO head outputs, valid whenever evt_valid=1, and held stable while evt_valid&!evt_ready.
  - Pop occurs on evt_valid&evt_ready.
  - Read is first-word-fall-through: a push into an empty FIFO shows evt_valid=1 on the next cycle.
- Timer wrap: never reaches 2**CNT_W-1, because the exit at DELAY-1 is guaranteed by the parameter rule.
- Multiple candidates in the same IDLE cycle: only the first in rr order is taken; the others remain candidates.

Decomposition:
- Shared package input_pkg holds:
  - FSM state encoding (IDLE=2'd0, TIMING=2'd1, COMMIT=2'd2).
  - Event type constants EVT_PRESS=1, EVT_RELEASE=0.
  - A clog2 function for ID width.
- Natural sub-module: evt_fifo (synchronous FWFT FIFO with parameters WIDTH and DEPTH, push/full and pop/empty ports).
- Synchronizer flops and FSM stay in the top module.

Test Plan (DELAY=8, NUM_BTN=4):
- Hold btn_raw[0]=1 from cycle 0 -> btn_clean[0]=1 at cycle 12; exactly one event {id=0, press=1}; busy high cycles 3..11.
- btn_raw[1]=1 for 5 cycles then 0 -> btn_clean[1] stays 0; no event; FSM back in IDLE with rr_ptr=2.
- btn_raw[2] and btn_raw[3] rise in the same cycle -> events id 2 then id 3; btn_clean[3] rises 10 cycles after btn_clean[2].
- evt_ready=0 while 5 press/release events occur -> FIFO holds the first 4 and evt_ovf=1. Then evt_ready=1 -> 4 events drain in order and evt_valid drops. ovf_clr -> evt_ovf=0.
- Press then release on btn 0, each held >12 cycles -> events {0,1} then {0,0}; btn_clean[0] returns to 0.
- Assert rst at TIMING timer=4 -> all outputs 0 immediately. After release with btn_raw still high, a fresh full DELAY+4 cycle debounce runs before the event.
